// File: rtl/kbd_ram_pkg.sv
// Shared constants and types for the keyboard/CPU RAM arbiter.
// Ring placement, pointer sizing and the grant encoding live here.
package kbd_ram_pkg;

  localparam logic [15:0] KB_BASE = 16'h00F0;
  localparam int          KB_LEN  = 8;

  function automatic int ptr_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_KB   = 2'd2
  } gnt_e;

endpackage

// File: rtl/kbd_ram_arbiter_if.sv
// CPU, keyboard and RAM-side signals of the arbiter, bundled.
// slave is the arbiter's view; master is the surrounding core's view.
interface kbd_ram_arbiter_if
  import kbd_ram_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int PTR_W  = ptr_w(KB_LEN)
) ();

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              kb_code_valid;
  logic [7:0]        kb_code;
  logic              kb_ovf_clr;
  logic              kb_overflow;
  logic [PTR_W-1:0]  kb_wptr;
  logic              grant_kb;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_d;
  logic              ram_we;
  logic [DATA_W-1:0] ram_q;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, kb_code_valid, kb_code, kb_ovf_clr, ram_q,
    output cpu_stall, cpu_rvalid, cpu_rdata, kb_overflow, kb_wptr, grant_kb, ram_addr, ram_d, ram_we
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, kb_code_valid, kb_code, kb_ovf_clr, ram_q,
    input  cpu_stall, cpu_rvalid, cpu_rdata, kb_overflow, kb_wptr, grant_kb, ram_addr, ram_d, ram_we
  );

endinterface

// File: rtl/kbd_code_fifo.sv
// Small synchronous FIFO for scan codes; a push into a full FIFO with no
// same-cycle pop is dropped and flagged on drop_o for that cycle.
module kbd_code_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         drop_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign head_o  = mem_q[rd_q];
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the slot the push needs, so full-with-pop still accepts.
  assign push_ok = push_i && (!full_o || pop_ok);
  assign drop_o  = push_i && full_o && !pop_ok;

  always_comb begin
    rd_d  = pop_ok  ? rd_q + 1'b1 : rd_q;
    wr_d  = push_ok ? wr_q + 1'b1 : wr_q;
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + 1'b1;
    if (pop_ok && !push_ok) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/kbd_ram_arbiter.sv
// Shares the single-port data RAM between CPU loads/stores and the scan-code
// ring writer; CPU wins unless the keyboard has been denied STARVE_MAX times.
module kbd_ram_arbiter
  import kbd_ram_pkg::gnt_e, kbd_ram_pkg::GNT_NONE, kbd_ram_pkg::GNT_CPU, kbd_ram_pkg::GNT_KB;
#(
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 16,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] KB_BASE    = ADDR_W'(kbd_ram_pkg::KB_BASE),
  parameter int                KB_LEN     = kbd_ram_pkg::KB_LEN,
  parameter int                STARVE_MAX = 3
) (
  input logic              CLOCK_50,
  input logic              RESET,
  kbd_ram_arbiter_if.slave bus
);

  localparam int             PTR_W      = kbd_ram_pkg::ptr_w(KB_LEN);
  localparam int             SW         = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]  STARVE_TOP = SW'(STARVE_MAX);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              ovf_q, ovf_d, rvalid_q, rvalid_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_d_q, ram_d_d;
  logic              ram_we;
  logic [7:0]        fifo_head;
  logic              fifo_full_unused, fifo_empty, fifo_drop;
  logic              kb_pend, force_kb;
  gnt_e              gnt;

  kbd_code_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (CLOCK_50),
    .rst_i   (RESET),
    .push_i  (bus.kb_code_valid),
    .pop_i   (gnt == GNT_KB),
    .din_i   (bus.kb_code),
    .head_o  (fifo_head),
    .full_o  (fifo_full_unused),
    .empty_o (fifo_empty),
    .drop_o  (fifo_drop)
  );

  assign kb_pend  = !fifo_empty;
  assign force_kb = kb_pend && (starve_q == STARVE_TOP);

  always_comb begin
    gnt = GNT_NONE;
    if (force_kb)         gnt = GNT_KB;
    else if (bus.cpu_req) gnt = GNT_CPU;
    else if (kb_pend)     gnt = GNT_KB;
  end

  // Idle cycles keep the last address/data on the RAM pins.
  always_comb begin
    ram_addr_d = ram_addr_q;
    ram_d_d    = ram_d_q;
    ram_we     = 1'b0;
    wptr_d     = wptr_q;
    starve_d   = starve_q;
    case (gnt)
      GNT_KB: begin
        ram_addr_d = KB_BASE + ADDR_W'(wptr_q);
        ram_d_d    = {{(DATA_W-8){1'b0}}, fifo_head};
        ram_we     = 1'b1;
        wptr_d     = wptr_q + 1'b1;
      end
      GNT_CPU: begin
        ram_addr_d = bus.cpu_addr;
        ram_d_d    = bus.cpu_wdata;
        ram_we     = bus.cpu_we;
      end
      default: ;
    endcase
    if (!kb_pend || gnt == GNT_KB)                   starve_d = '0;
    else if (gnt == GNT_CPU && starve_q != STARVE_TOP) starve_d = starve_q + 1'b1;
    rvalid_d = (gnt == GNT_CPU) && !bus.cpu_we;
    ovf_d    = fifo_drop ? 1'b1 : (bus.kb_ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      wptr_q     <= '0;
      starve_q   <= '0;
      ovf_q      <= 1'b0;
      rvalid_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_d_q    <= '0;
    end else begin
      wptr_q     <= wptr_d;
      starve_q   <= starve_d;
      ovf_q      <= ovf_d;
      rvalid_q   <= rvalid_d;
      ram_addr_q <= ram_addr_d;
      ram_d_q    <= ram_d_d;
    end
  end

  assign bus.cpu_stall   = bus.cpu_req && (gnt != GNT_CPU);
  assign bus.cpu_rvalid  = rvalid_q;
  assign bus.cpu_rdata   = bus.ram_q;
  assign bus.kb_overflow = ovf_q;
  assign bus.kb_wptr     = wptr_q;
  assign bus.grant_kb    = (gnt == GNT_KB);
  assign bus.ram_addr    = ram_addr_d;
  assign bus.ram_d       = ram_d_d;
  assign bus.ram_we      = ram_we;

endmodule

// File: tb/tb_kbd_ram_arbiter.sv
// Directed scenarios followed by random traffic, each cycle compared against
// a queue-based model of the arbitration rules and a shadow of RAM contents.
module tb_kbd_ram_arbiter;
  import kbd_ram_pkg::*;

  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kbd_ram_arbiter_if bus_if ();

  kbd_ram_arbiter dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .bus      (bus_if.slave)
  );

  // Behavioural RAM: read-first, one cycle of read latency.
  logic [15:0] ram_mem [256] = '{default: 16'h0000};
  always @(posedge clk) begin
    bus_if.ram_q <= ram_mem[bus_if.ram_addr[7:0]];
    if (bus_if.ram_we) ram_mem[bus_if.ram_addr[7:0]] <= bus_if.ram_d;
  end

  int passed = 0;
  int total  = 0;

  logic [7:0]  m_q [$];
  int          m_wptr, m_starve;
  bit          m_ovf, m_known, m_rvalid;
  logic [15:0] m_last_addr, m_last_d, m_rdata;
  logic [15:0] shadow [256] = '{default: 16'h0000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wptr   = 0;
    m_starve = 0;
    m_ovf    = 0;
    m_known  = 0;
    m_rvalid = 0;
  endtask

  task automatic drive(input bit req, input bit we, input logic [15:0] a, input logic [15:0] wd,
                       input bit kv, input logic [7:0] code, input bit clr);
    bus_if.cpu_req       = req;
    bus_if.cpu_we        = we;
    bus_if.cpu_addr      = a;
    bus_if.cpu_wdata     = wd;
    bus_if.kb_code_valid = kv;
    bus_if.kb_code       = code;
    bus_if.kb_ovf_clr    = clr;
  endtask

  task automatic idle();
    drive(0, 0, 16'h0000, 16'h0000, 0, 8'h00, 0);
  endtask

  // Check this cycle's outputs at the falling edge, then advance the model.
  task automatic cycle();
    bit pend, frc, gk, gc, req, we, kv, clr;
    logic [15:0] a, wd, ea, ed;
    logic [7:0] code;
    @(negedge clk);
    req = bus_if.cpu_req;  we = bus_if.cpu_we;  a = bus_if.cpu_addr;  wd = bus_if.cpu_wdata;
    kv = bus_if.kb_code_valid;  code = bus_if.kb_code;  clr = bus_if.kb_ovf_clr;
    pend = (m_q.size() != 0);
    frc  = pend && (m_starve == STARVE_MAX);
    gk   = frc || (!req && pend);
    gc   = !frc && req;
    ea = m_last_addr;  ed = m_last_d;
    if (gk) begin
      ea = KB_BASE + 16'(m_wptr);
      ed = {8'h00, m_q[0]};
    end else if (gc) begin
      ea = a;
      ed = wd;
    end
    chk("grant_kb", bus_if.grant_kb, gk);
    chk("cpu_stall", bus_if.cpu_stall, req && !gc);
    chk("ram_we", bus_if.ram_we, gk || (gc && we));
    if (gk || gc || m_known) begin
      chk("ram_addr", bus_if.ram_addr, ea);
      chk("ram_d", bus_if.ram_d, ed);
    end
    chk("kb_overflow", bus_if.kb_overflow, m_ovf);
    chk("kb_wptr", bus_if.kb_wptr, m_wptr);
    chk("cpu_rvalid", bus_if.cpu_rvalid, m_rvalid);
    if (m_rvalid) chk("cpu_rdata", bus_if.cpu_rdata, m_rdata);

    m_rvalid = 0;
    if (gk) begin
      shadow[ea[7:0]] = ed;
      void'(m_q.pop_front());
      m_wptr = (m_wptr + 1) % KB_LEN;
    end
    if (gc) begin
      if (we) shadow[a[7:0]] = wd;
      else begin
        m_rvalid = 1;
        m_rdata  = shadow[a[7:0]];
      end
    end
    if (gk || gc) begin
      m_last_addr = ea;
      m_last_d    = ed;
      m_known     = 1;
    end
    if (clr) m_ovf = 0;
    if (kv) begin
      if (m_q.size() < FIFO_DEPTH) m_q.push_back(code);
      else m_ovf = 1;
    end
    if (!pend || gk) m_starve = 0;
    else if (m_starve < STARVE_MAX) m_starve++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    model_reset();
    #3;
    chk("rst_grant_kb", bus_if.grant_kb, 1'b0);
    chk("rst_kb_wptr", bus_if.kb_wptr, 0);
    chk("rst_cpu_rvalid", bus_if.cpu_rvalid, 1'b0);
    chk("rst_kb_overflow", bus_if.kb_overflow, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // CPU store then load with the keyboard idle
    drive(1, 1, 16'h0010, 16'hBEEF, 0, 8'h00, 0); cycle();
    drive(1, 0, 16'h0010, 16'h0000, 0, 8'h00, 0); cycle();
    idle(); cycle();
    chk("load_beef", m_rdata, bus_if.cpu_rdata);
    cycle();

    // Single scan code with the CPU idle
    drive(0, 0, 16'h0000, 16'h0000, 1, 8'h1C, 0); cycle();
    idle(); cycle();
    chk("ring_word_f0", ram_mem[8'hF0], 16'h001C);
    cycle();

    // Starvation: CPU requesting continuously while one code waits
    drive(1, 0, 16'h0020, 16'h0000, 1, 8'h32, 0); cycle();
    for (int i = 0; i < 6; i++) begin
      drive(1, i[0], 16'h0021 + 16'(i), 16'h1000 + 16'(i), 0, 8'h00, 0);
      cycle();
    end
    idle(); cycle();

    // Overflow: burst of codes while the CPU hogs the port
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 16'h0030, 16'h0000, 1, 8'h40 + 8'(i), 0);
      cycle();
    end
    idle();
    for (int i = 0; i < 6; i++) cycle();
    drive(0, 0, 16'h0000, 16'h0000, 0, 8'h00, 1); cycle();
    idle(); cycle();

    // Ring wrap: nine codes through the eight-word ring
    for (int i = 0; i < 9; i++) begin
      drive(0, 0, 16'h0000, 16'h0000, 1, 8'h60 + 8'(i), 0);
      cycle();
    end
    idle(); cycle(); cycle();

    // Reset while codes are queued behind CPU traffic
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 16'h0050, 16'h0000, 1, 8'h70 + 8'(i), 0);
      cycle();
    end
    drive(1, 0, 16'h0050, 16'h0000, 0, 8'h00, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_grant_kb", bus_if.grant_kb, 1'b0);
    chk("midrst_kb_wptr", bus_if.kb_wptr, 0);
    chk("midrst_cpu_rvalid", bus_if.cpu_rvalid, 1'b0);
    chk("midrst_cpu_stall", bus_if.cpu_stall, 1'b0);
    model_reset();
    idle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 65, $urandom_range(0, 1) == 1,
            {8'h00, 8'($urandom)}, 16'($urandom),
            $urandom_range(0, 99) < 40, 8'($urandom),
            $urandom_range(0, 99) < 5);
      cycle();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
